multdiv_issue_ctrl: RTL and testbench

MULTDIV_ISSUE_CTRL -- requirements
Module: multdiv_issue_ctrl

---
 rtl/multdiv_issue_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_issue_ctrl
// Purpose  : Issues one multiply/divide at a time to a multi-cycle multdiv
//            unit, stalls the pipeline while it runs and holds the result
//            until writeback consumes it. Optional watchdog: MULTDIV_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_issue_ctrl #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic             clock,
    input  logic             ctrl_reset,

    input  logic             req_valid,
    input  logic             req_is_div,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [4:0]       req_rd,
    output logic             req_ready,

    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_operandA,
    output logic [WIDTH-1:0] data_operandB,
    input  logic [WIDTH-1:0] data_result,
    input  logic             data_exception,
    input  logic             data_resultRDY,

    input  logic             flush,
    output logic             stall,

    output logic             wb_valid,
    output logic [WIDTH-1:0] wb_result,
    output logic [4:0]       wb_rd,
    output logic             wb_exception,
    input  logic             wb_ack
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] opa_q,    opa_d;
    logic [WIDTH-1:0] opb_q,    opb_d;
    logic [4:0]       rd_q,     rd_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             exc_q,    exc_d;

    logic             w_accept;
    logic             w_timeout;

    assign w_accept = req_valid & req_ready & ~flush;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counts completed WAIT cycles; the limit is hit in the last allowed one.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == WAIT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    assign w_timeout = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (data_resultRDY || w_timeout) state_d = HOLD;
            HOLD:    if (wb_ack) state_d = w_accept ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = (state_q == IDLE) || ((state_q == HOLD) && wb_ack);
        ctrl_MULT = (state_q == ISSUE) && !is_div_q;
        ctrl_DIV  = (state_q == ISSUE) &&  is_div_q;
        stall     = (state_q == ISSUE) || (state_q == WAIT) ||
                    ((state_q == HOLD) && !wb_ack);
        wb_valid  = (state_q == HOLD);
    end

    assign data_operandA = opa_q;
    assign data_operandB = opb_q;
    assign wb_result     = res_q;
    assign wb_rd         = rd_q;
    assign wb_exception  = exc_q;

    // ------------------------------------------------------------------
    // Payload capture
    // ------------------------------------------------------------------
    always_comb begin
        is_div_d = is_div_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rd_d     = rd_q;
        res_d    = res_q;
        exc_d    = exc_q;

        if (w_accept) begin
            is_div_d = req_is_div;
            opa_d    = req_a;
            opb_d    = req_b;
            rd_d     = req_rd;
        end

        // A real completion in the limit cycle wins over the watchdog.
        if ((state_q == WAIT) && !flush) begin
            if (data_resultRDY) begin
                res_d = data_result;
                exc_d = data_exception;
            end else if (w_timeout) begin
                res_d = '0;
                exc_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            is_div_q <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            rd_q     <= '0;
            res_q    <= '0;
            exc_q    <= 1'b0;
        end else begin
            is_div_q <= is_div_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rd_q     <= rd_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_issue_ctrl
// Purpose  : Self-checking bench for multdiv_issue_ctrl: vector table,
//            directed corner sequences and a randomized transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_issue_ctrl;

    localparam int W  = 32;
    localparam int TO = 40;

    logic         clock = 1'b0;
    logic         ctrl_reset;
    logic         req_valid, req_is_div;
    logic [W-1:0] req_a, req_b;
    logic [4:0]   req_rd;
    logic         req_ready;
    logic         ctrl_MULT, ctrl_DIV;
    logic [W-1:0] data_operandA, data_operandB;
    logic [W-1:0] data_result;
    logic         data_exception, data_resultRDY;
    logic         flush, stall;
    logic         wb_valid;
    logic [W-1:0] wb_result;
    logic [4:0]   wb_rd;
    logic         wb_exception, wb_ack;

    multdiv_issue_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .req_valid      (req_valid),
        .req_is_div     (req_is_div),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_rd         (req_rd),
        .req_ready      (req_ready),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .flush          (flush),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_result      (wb_result),
        .wb_rd          (wb_rd),
        .wb_exception   (wb_exception),
        .wb_ack         (wb_ack)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid      = 1'b0;
        req_is_div     = 1'b0;
        req_a          = '0;
        req_b          = '0;
        req_rd         = '0;
        data_result    = '0;
        data_exception = 1'b0;
        data_resultRDY = 1'b0;
        flush          = 1'b0;
        wb_ack         = 1'b0;
    endtask

    // Presents a request in an IDLE cycle; returns at the start of the ISSUE cycle.
    task automatic issue(input logic div, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rd);
        req_valid  = 1'b1;
        req_is_div = div;
        req_a      = a;
        req_b      = b;
        req_rd     = rd;
        #1;
        chk1("issue.ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic         vld, div;
        logic [W-1:0] a, b;
        logic [4:0]   rd;
        logic         rdy;
        logic [W-1:0] res;
        logic         exc, fl, ack;
        logic         e_ready, e_mult, e_div, e_stall, e_wbv;
        logic [W-1:0] e_opa, e_opb, e_res;
        logic [4:0]   e_rd;
        logic         e_exc;
    } vec_t;

    vec_t vt[14];

    // Transaction-level reference for the random phase
    logic         m_busy, m_started, m_done, m_div, m_exc;
    logic [W-1:0] m_a, m_b, m_res;
    logic [4:0]   m_rd;
    int           m_wait;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL sim_timeout: got no end of test expected end of test");
        $fatal(1);
    end

    initial begin
        int pulses, stall_low, wbv_seen, first_wbv;
        logic e_ready, e_mult, e_div, e_stall, e_wbv, acc;

        //          vld div a       b       rd    rdy res      exc fl  ack  rdy mul div stl wbv opa     opb     res     rd    exc
        vt[0]  = '{'0, '0, 32'd0,  32'd0,  5'd0, '0, 32'd0,  '0, '0, '0,  '1, '0, '0, '0, '0, 32'd0,  32'd0,  32'd0,  5'd0, '0};
        vt[1]  = '{'1, '0, 32'd6,  32'd7,  5'd3, '0, 32'd0,  '0, '0, '0,  '1, '0, '0, '0, '0, 32'd0,  32'd0,  32'd0,  5'd0, '0};
        vt[2]  = '{'0, '0, 32'd0,  32'd0,  5'd0, '1, 32'd99, '0, '0, '0,  '0, '1, '0, '1, '0, 32'd6,  32'd7,  32'd0,  5'd0, '0};
        vt[3]  = '{'0, '0, 32'd0,  32'd0,  5'd0, '0, 32'd0,  '0, '0, '0,  '0, '0, '0, '1, '0, 32'd0,  32'd0,  32'd0,  5'd0, '0};
        vt[4]  = '{'0, '0, 32'd0,  32'd0,  5'd0, '1, 32'd42, '0, '0, '0,  '0, '0, '0, '1, '0, 32'd0,  32'd0,  32'd0,  5'd0, '0};
        vt[5]  = '{'0, '0, 32'd0,  32'd0,  5'd0, '0, 32'd0,  '0, '0, '0,  '0, '0, '0, '1, '1, 32'd0,  32'd0,  32'd42, 5'd3, '0};
        vt[6]  = '{'1, '1, 32'd10, 32'd0,  5'd5, '0, 32'd0,  '0, '0, '1,  '1, '0, '0, '0, '1, 32'd0,  32'd0,  32'd42, 5'd3, '0};
        vt[7]  = '{'0, '0, 32'd0,  32'd0,  5'd0, '0, 32'd0,  '0, '0, '0,  '0, '0, '1, '1, '0, 32'd10, 32'd0,  32'd0,  5'd0, '0};
        vt[8]  = '{'0, '0, 32'd0,  32'd0,  5'd0, '1, 32'd0,  '1, '0, '0,  '0, '0, '0, '1, '0, 32'd0,  32'd0,  32'd0,  5'd0, '0};
        vt[9]  = '{'0, '0, 32'd0,  32'd0,  5'd0, '1, 32'd77, '0, '0, '0,  '0, '0, '0, '1, '1, 32'd0,  32'd0,  32'd0,  5'd5, '1};
        vt[10] = '{'0, '0, 32'd0,  32'd0,  5'd0, '0, 32'd0,  '0, '0, '1,  '1, '0, '0, '0, '1, 32'd0,  32'd0,  32'd0,  5'd5, '1};
        vt[11] = '{'0, '0, 32'd0,  32'd0,  5'd0, '1, 32'd55, '0, '0, '0,  '1, '0, '0, '0, '0, 32'd0,  32'd0,  32'd0,  5'd0, '0};
        vt[12] = '{'1, '0, 32'd1,  32'd1,  5'd1, '0, 32'd0,  '0, '1, '0,  '1, '0, '0, '0, '0, 32'd0,  32'd0,  32'd0,  5'd0, '0};
        vt[13] = '{'0, '0, 32'd0,  32'd0,  5'd0, '0, 32'd0,  '0, '0, '0,  '1, '0, '0, '0, '0, 32'd0,  32'd0,  32'd0,  5'd0, '0};

        // ---------------- reset state ----------------
        clear_inputs();
        ctrl_reset = 1'b0;
        #3;
        chk1("rst.ready",  req_ready,     1'b1);
        chk1("rst.mult",   ctrl_MULT,     1'b0);
        chk1("rst.div",    ctrl_DIV,      1'b0);
        chk1("rst.stall",  stall,         1'b0);
        chk1("rst.wbv",    wb_valid,      1'b0);
        chkw("rst.opa",    data_operandA, '0);
        chkw("rst.opb",    data_operandB, '0);
        chkw("rst.wbres",  wb_result,     '0);
        chkw("rst.wbrd",   W'(wb_rd),     '0);
        chk1("rst.wbexc",  wb_exception,  1'b0);
        tick();
        tick();
        ctrl_reset = 1'b1;

        // ---------------- vector table ----------------
        for (int i = 0; i < 14; i++) begin
            req_valid      = vt[i].vld;
            req_is_div     = vt[i].div;
            req_a          = vt[i].a;
            req_b          = vt[i].b;
            req_rd         = vt[i].rd;
            data_resultRDY = vt[i].rdy;
            data_result    = vt[i].res;
            data_exception = vt[i].exc;
            flush          = vt[i].fl;
            wb_ack         = vt[i].ack;
            #1;
            chk1($sformatf("vec%0d.ready", i), req_ready, vt[i].e_ready);
            chk1($sformatf("vec%0d.mult", i),  ctrl_MULT, vt[i].e_mult);
            chk1($sformatf("vec%0d.div", i),   ctrl_DIV,  vt[i].e_div);
            chk1($sformatf("vec%0d.stall", i), stall,     vt[i].e_stall);
            chk1($sformatf("vec%0d.wbv", i),   wb_valid,  vt[i].e_wbv);
            if (vt[i].e_mult || vt[i].e_div) begin
                chkw($sformatf("vec%0d.opa", i), data_operandA, vt[i].e_opa);
                chkw($sformatf("vec%0d.opb", i), data_operandB, vt[i].e_opb);
            end
            if (vt[i].e_wbv) begin
                chkw($sformatf("vec%0d.wbres", i), wb_result,    vt[i].e_res);
                chkw($sformatf("vec%0d.wbrd", i),  W'(wb_rd),    W'(vt[i].e_rd));
                chk1($sformatf("vec%0d.wbexc", i), wb_exception, vt[i].e_exc);
            end
            tick();
        end
        clear_inputs();

        // ---------------- mult 6*7, RDY 32 cycles after the pulse ----------------
        issue(1'b0, 32'd6, 32'd7, 5'd3);
        #1;
        chk1("m67.mult", ctrl_MULT, 1'b1);
        chk1("m67.div",  ctrl_DIV,  1'b0);
        pulses = 0;
        stall_low = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 32) begin
                data_resultRDY = 1'b1;
                data_result    = 32'd42;
            end
            #1;
            if (ctrl_MULT || ctrl_DIV) pulses++;
            if (!stall) stall_low++;
        end
        chkw("m67.extra_pulses", W'(pulses),    '0);
        chkw("m67.stall_low",    W'(stall_low), '0);
        tick();
        clear_inputs();
        #1;
        chk1("m67.wbv",   wb_valid,     1'b1);
        chkw("m67.wbres", wb_result,    32'd42);
        chkw("m67.wbrd",  W'(wb_rd),    32'd3);
        chk1("m67.wbexc", wb_exception, 1'b0);
        chk1("m67.stall", stall,        1'b1);
        wb_ack = 1'b1;
        #1;
        chk1("m67.stall_ack", stall, 1'b0);
        tick();
        clear_inputs();
        #1;
        chk1("m67.idle_wbv",   wb_valid,  1'b0);
        chk1("m67.idle_ready", req_ready, 1'b1);

        // ---------------- div 10/0 with exception held until ack ----------------
        issue(1'b1, 32'd10, 32'd0, 5'd9);
        #1;
        chk1("d100.div",  ctrl_DIV,  1'b1);
        chk1("d100.mult", ctrl_MULT, 1'b0);
        tick();
        tick();
        data_resultRDY = 1'b1;
        data_exception = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1($sformatf("d100.hold%0d.wbv", i), wb_valid,     1'b1);
            chk1($sformatf("d100.hold%0d.exc", i), wb_exception, 1'b1);
            chkw($sformatf("d100.hold%0d.rd", i),  W'(wb_rd),    32'd9);
            tick();
        end

        // ---------------- back-to-back: ack + mult 2*3 in the same HOLD cycle ----------------
        wb_ack = 1'b1;
        req_valid = 1'b1;
        req_a = 32'd2;
        req_b = 32'd3;
        req_rd = 5'd4;
        #1;
        chk1("b2b.ready", req_ready, 1'b1);
        tick();
        clear_inputs();
        #1;
        chk1("b2b.mult", ctrl_MULT,     1'b1);
        chkw("b2b.opa",  data_operandA, 32'd2);
        chkw("b2b.opb",  data_operandB, 32'd3);

        // ---------------- flush at WAIT cycle 10, RDY later ignored ----------------
        wbv_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 10) flush = 1'b1;
            #1;
            if (wb_valid) wbv_seen++;
        end
        chk1("flush.stall_during", stall, 1'b1);
        tick();
        flush = 1'b0;
        #1;
        chk1("flush.stall_after", stall,     1'b0);
        chk1("flush.ready_after", req_ready, 1'b1);
        for (int i = 12; i <= 36; i++) begin
            tick();
            data_resultRDY = (i == 32);
            data_result    = 32'd6;
            #1;
            if (wb_valid) wbv_seen++;
            if (stall) stall_low++;
        end
        clear_inputs();
        chkw("flush.wbv_seen", W'(wbv_seen),  '0);
        chkw("flush.stall_hi", W'(stall_low), '0);

        // ---------------- async reset mid-WAIT, later RDY ignored ----------------
        tick();
        issue(1'b0, 32'd5, 32'd5, 5'd7);
        tick();
        tick();
        tick();
        ctrl_reset = 1'b0;
        #1;
        chk1("rstw.ready", req_ready,     1'b1);
        chk1("rstw.stall", stall,         1'b0);
        chk1("rstw.wbv",   wb_valid,      1'b0);
        chkw("rstw.opa",   data_operandA, '0);
        chkw("rstw.wbrd",  W'(wb_rd),     '0);
        tick();
        ctrl_reset = 1'b1;
        data_resultRDY = 1'b1;
        data_result = 32'h1234;
        #1;
        chk1("rstw.rdy_ready", req_ready, 1'b1);
        tick();
        clear_inputs();
        #1;
        chk1("rstw.post_wbv",   wb_valid,  1'b0);
        chk1("rstw.post_stall", stall,     1'b0);
        chkw("rstw.post_res",   wb_result, '0);

        // ---------------- flush beats same-cycle ack + req_valid in HOLD ----------------
        issue(1'b0, 32'd8, 32'd8, 5'd2);
        tick();
        data_resultRDY = 1'b1;
        data_result = 32'd64;
        tick();
        clear_inputs();
        flush = 1'b1;
        wb_ack = 1'b1;
        req_valid = 1'b1;
        req_a = 32'd11;
        #1;
        chk1("fhold.wbv", wb_valid, 1'b1);
        tick();
        clear_inputs();
        #1;
        chk1("fhold.mult",  ctrl_MULT, 1'b0);
        chk1("fhold.wbv2",  wb_valid,  1'b0);
        chk1("fhold.ready", req_ready, 1'b1);

        // ---------------- flush in ISSUE: no pulse afterwards ----------------
        issue(1'b1, 32'd3, 32'd1, 5'd1);
        flush = 1'b1;
        #1;
        chk1("fiss.div", ctrl_DIV, 1'b1);
        tick();
        flush = 1'b0;
        #1;
        chk1("fiss.div_after", ctrl_DIV,  1'b0);
        chk1("fiss.stall",     stall,     1'b0);
        chk1("fiss.ready",     req_ready, 1'b1);

        // ---------------- watchdog ----------------
        tick();
        issue(1'b0, 32'd1, 32'd2, 5'd6);
        first_wbv = 0;
`ifdef MULTDIV_TIMEOUT_EN
        for (int i = 1; i <= 60; i++) begin
            tick();
            #1;
            if (wb_valid && first_wbv == 0) first_wbv = i;
        end
        chkw("to.first_wbv", W'(first_wbv), W'(TO + 1));
        chk1("to.wbexc",     wb_exception,  1'b1);
        chkw("to.wbres",     wb_result,     '0);
        wb_ack = 1'b1;
        tick();
        clear_inputs();
        issue(1'b0, 32'd1, 32'd2, 5'd6);
        for (int i = 1; i <= TO + 1; i++) begin
            tick();
            data_resultRDY = (i == TO);
            data_result    = 32'd2;
        end
        clear_inputs();
        #1;
        chk1("to_rdy.wbv",   wb_valid,     1'b1);
        chkw("to_rdy.wbres", wb_result,    32'd2);
        chk1("to_rdy.wbexc", wb_exception, 1'b0);
`else
        for (int i = 1; i <= 100; i++) begin
            tick();
            #1;
            if (wb_valid && first_wbv == 0) first_wbv = i;
        end
        chkw("nto.first_wbv", W'(first_wbv), '0);
        chk1("nto.stall",     stall,         1'b1);
`endif
        flush = 1'b1;
        tick();
        clear_inputs();

        // ---------------- randomized traffic vs transaction model ----------------
        m_busy = 1'b0; m_started = 1'b0; m_done = 1'b0; m_div = 1'b0; m_exc = 1'b0;
        m_a = '0; m_b = '0; m_res = '0; m_rd = '0; m_wait = 0;
        for (int c = 0; c < 2000; c++) begin
            req_valid      = ($urandom_range(0, 1) == 1);
            req_is_div     = ($urandom_range(0, 1) == 1);
            req_a          = $urandom();
            req_b          = $urandom();
            req_rd         = 5'($urandom_range(0, 31));
            data_resultRDY = ($urandom_range(0, 3) == 0);
            data_result    = $urandom();
            data_exception = ($urandom_range(0, 7) == 0);
            flush          = ($urandom_range(0, 24) == 0);
            wb_ack         = ($urandom_range(0, 1) == 1);
            #1;
            e_ready = !m_busy || (m_done && wb_ack);
            e_mult  = m_busy && !m_started && !m_div;
            e_div   = m_busy && !m_started &&  m_div;
            e_stall = m_busy && !(m_done && wb_ack);
            e_wbv   = m_busy && m_done;
            chk1($sformatf("rnd%0d.ready", c), req_ready, e_ready);
            chk1($sformatf("rnd%0d.mult", c),  ctrl_MULT, e_mult);
            chk1($sformatf("rnd%0d.div", c),   ctrl_DIV,  e_div);
            chk1($sformatf("rnd%0d.stall", c), stall,     e_stall);
            chk1($sformatf("rnd%0d.wbv", c),   wb_valid,  e_wbv);
            if (m_busy && !m_done) begin
                chkw($sformatf("rnd%0d.opa", c), data_operandA, m_a);
                chkw($sformatf("rnd%0d.opb", c), data_operandB, m_b);
            end
            if (e_wbv) begin
                chkw($sformatf("rnd%0d.wbres", c), wb_result,    m_res);
                chkw($sformatf("rnd%0d.wbrd", c),  W'(wb_rd),    W'(m_rd));
                chk1($sformatf("rnd%0d.wbexc", c), wb_exception, m_exc);
            end

            acc = req_valid && e_ready && !flush;
            if (flush) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (!m_started) begin
                    m_started = 1'b1;
                    m_wait = 0;
                end else if (!m_done) begin
                    if (data_resultRDY) begin
                        m_done = 1'b1;
                        m_res  = data_result;
                        m_exc  = data_exception;
                    end else begin
                        m_wait++;
`ifdef MULTDIV_TIMEOUT_EN
                        if (m_wait == TO) begin
                            m_done = 1'b1;
                            m_res  = '0;
                            m_exc  = 1'b1;
                        end
`endif
                    end
                end else if (wb_ack) begin
                    m_busy = 1'b0;
                end
            end
            if (acc) begin
                m_busy = 1'b1; m_started = 1'b0; m_done = 1'b0;
                m_div = req_is_div; m_a = req_a; m_b = req_b; m_rd = req_rd;
            end
            tick();
        end
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
